ahb_bridge_arbiter: RTL

Round-robin arbiter and transfer sequencer that shares the single AHB slave port of the AHB-to-APB bridge among NUM_REQ on-chip requesters (accelerator control, DMA, debug).
Accepts one single-beat request at a time and drives an AHB-lite NONSEQ transfer into the bridge. Waits out the bridge's Hreadyout stalls, then returns read data and status to the granted requester.
Sits between the requesters and the bridge top in the accelerator subsystem.

---
 rtl/ahb_bridge_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ahb_bridge_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bridge_arbiter
// Description : Round-robin arbiter and single-beat AHB-lite transfer
//               sequencer that shares the AHB slave port of the AHB-to-APB
//               bridge among NUM_REQ requesters.
//               Optional feature macro: ARB_BRIDGE_TIMEOUT_EN (DATA-phase
//               stall watchdog plus sticky timeout_flag output).
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_bridge_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       Hclk,
    input  logic                       Hreset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*AW-1:0]      req_addr,
    input  logic [NUM_REQ*DW-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DW-1:0]              rsp_rdata,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
`ifdef ARB_BRIDGE_TIMEOUT_EN
    output logic                       timeout_flag,
`endif
    output logic                       Hwrite,
    output logic                       Hreadyin,
    output logic [1:0]                 Htrans,
    output logic [AW-1:0]              Haddr,
    output logic [DW-1:0]              Hwdata,
    input  logic                       Hreadyout,
    input  logic [1:0]                 Hresp,
    input  logic [DW-1:0]              Hrdata
);

    localparam int         c_gw      = $clog2(NUM_REQ);
    localparam logic [1:0] c_idle    = 2'b00;
    localparam logic [1:0] c_nonseq  = 2'b10;
    localparam logic [1:0] c_err     = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [c_gw-1:0]   r_grant;
    logic [c_gw-1:0]   r_ptr;
    logic              r_write;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;
    logic [DW-1:0]     r_rdata;
    logic              r_err;
    logic              w_found;
    logic [c_gw-1:0]   w_win;
    logic              w_timeout;

    // Round-robin search: first valid requester after the pointer, wrapping.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = c_gw'(idx);
            end
        end
    end

`ifdef ARB_BRIDGE_TIMEOUT_EN
    logic [15:0] r_stall;
    logic        r_timeout_flag;

    assign w_timeout    = (r_state == S_DATA) && !Hreadyout &&
                          (r_stall == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = r_timeout_flag;

    // Stall counter cleared on DATA entry; sticky flag set on watchdog expiry.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_stall        <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (r_state == S_ADDR && Hreadyout)
                r_stall <= '0;
            else if (r_state == S_DATA && !Hreadyout)
                r_stall <= r_stall + 16'd1;
            if (w_timeout)
                r_timeout_flag <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register and per-transfer capture of request and response.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= c_gw'(NUM_REQ - 1);
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (w_found) begin
                    r_grant <= w_win;
                    r_write <= req_write[w_win];
                    r_addr  <= req_addr[w_win*AW +: AW];
                    r_wdata <= req_wdata[w_win*DW +: DW];
                end
                S_ADDR: if (Hreadyout) r_ptr <= r_grant;
                S_DATA: if (Hreadyout) begin
                    r_rdata <= Hrdata;
                    r_err   <= (Hresp == c_err);
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and bus/handshake outputs decoded from the state.
    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = '0;
        Htrans    = c_idle;
        Hreadyin  = 1'b1;
        case (r_state)
            S_IDLE: if (w_found) w_next = S_ADDR;
            S_ADDR: begin
                Htrans = c_nonseq;
                if (Hreadyout) begin
                    req_ready[r_grant] = 1'b1;
                    w_next             = S_DATA;
                end
            end
            S_DATA: begin
                Hreadyin = Hreadyout;
                if (Hreadyout || w_timeout) w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid[r_grant] = 1'b1;
                w_next             = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign grant_id  = r_grant;
    assign Hwrite    = r_write;
    assign Haddr     = r_addr;
    assign Hwdata    = r_wdata;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire
